// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32 core.
// RegDst encodings, datapath width and the ID/EX bundle.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] REGDST_ALU  = 2'b00;
    localparam logic [1:0] REGDST_MEM  = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;
    localparam logic [1:0] REGDST_CMP  = 2'b11;

    typedef struct packed {
        logic            Mwk;
        logic [6:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] ReadData1;
        logic [XLEN-1:0] ReadData2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            RegWr;
        logic [1:0]      RegDst;
        logic [3:0]      ALUOp;
        logic            MemWr;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bus: decoded ID fields, downstream producers,
// flush, and the registered EX fields plus stall status.
interface id_ex_if;
    import pipe_pkg::*;

    logic            id_Mwk;
    logic [6:0]      id_op;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [XLEN-1:0] id_ReadData1;
    logic [XLEN-1:0] id_ReadData2;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            id_RegWr;
    logic [1:0]      id_RegDst;
    logic [3:0]      id_ALUOp;
    logic            id_MemWr;

    logic            mem_Mwk;
    logic            mem_RegWr;
    logic [1:0]      mem_RegDst;
    logic [4:0]      mem_rd;
    logic            wb_Mwk;
    logic            wb_RegWr;
    logic [1:0]      wb_RegDst;
    logic [4:0]      wb_rd;
    logic            flush;

    logic            ex_Mwk;
    logic [6:0]      ex_op;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_ReadData1;
    logic [XLEN-1:0] ex_ReadData2;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic            ex_RegWr;
    logic [1:0]      ex_RegDst;
    logic [3:0]      ex_ALUOp;
    logic            ex_MemWr;
    logic            stall;
    logic [1:0]      bubble_cnt;

    modport master (
        output id_Mwk, id_op, id_rs1, id_rs2, id_rd,
        output id_use_rs1, id_use_rs2,
        output id_ReadData1, id_ReadData2, id_imm, id_pc,
        output id_RegWr, id_RegDst, id_ALUOp, id_MemWr,
        output mem_Mwk, mem_RegWr, mem_RegDst, mem_rd,
        output wb_Mwk, wb_RegWr, wb_RegDst, wb_rd, flush,
        input  ex_Mwk, ex_op, ex_rs1, ex_rs2, ex_rd,
        input  ex_ReadData1, ex_ReadData2, ex_imm, ex_pc,
        input  ex_RegWr, ex_RegDst, ex_ALUOp, ex_MemWr,
        input  stall, bubble_cnt
    );

    modport slave (
        input  id_Mwk, id_op, id_rs1, id_rs2, id_rd,
        input  id_use_rs1, id_use_rs2,
        input  id_ReadData1, id_ReadData2, id_imm, id_pc,
        input  id_RegWr, id_RegDst, id_ALUOp, id_MemWr,
        input  mem_Mwk, mem_RegWr, mem_RegDst, mem_rd,
        input  wb_Mwk, wb_RegWr, wb_RegDst, wb_rd, flush,
        output ex_Mwk, ex_op, ex_rs1, ex_rs2, ex_rd,
        output ex_ReadData1, ex_ReadData2, ex_imm, ex_pc,
        output ex_RegWr, ex_RegDst, ex_ALUOp, ex_MemWr,
        output stall, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Bubble requirement for the ID instruction against the
// ex/mem/wb producers that forwarding cannot cover in time.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int LINK_BUBBLES = 3
) (
    input  logic       id_Mwk,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_Mwk,
    input  logic       ex_RegWr,
    input  logic [1:0] ex_RegDst,
    input  logic [4:0] ex_rd,
    input  logic       mem_Mwk,
    input  logic       mem_RegWr,
    input  logic [1:0] mem_RegDst,
    input  logic [4:0] mem_rd,
    input  logic       wb_Mwk,
    input  logic       wb_RegWr,
    input  logic [1:0] wb_RegDst,
    input  logic [4:0] wb_rd,
    output logic [1:0] need
);

    localparam logic [1:0] N_LD  = 2'(LOAD_BUBBLES);
    localparam logic [1:0] N_LK  = 2'(LINK_BUBBLES);
    localparam logic [1:0] N_LK1 = 2'(LINK_BUBBLES - 1);
    localparam logic [1:0] N_LK2 = 2'(LINK_BUBBLES - 2);

    logic hit_ex, hit_mem, hit_wb;
    logic [1:0] n_ex, n_mem, n_wb, n_max;

    function automatic logic hit(
        input logic       v,
        input logic       w,
        input logic [4:0] rd
    );
        return v && w && (rd != 5'd0) && id_Mwk &&
               ((use_rs1 && rd == rs1) || (use_rs2 && rd == rs2));
    endfunction

    assign hit_ex  = hit(ex_Mwk, ex_RegWr, ex_rd);
    assign hit_mem = hit(mem_Mwk, mem_RegWr, mem_rd);
    assign hit_wb  = hit(wb_Mwk, wb_RegWr, wb_rd);

    // ALU/compare results forward from any stage; only
    // loads in EX and link writers anywhere need bubbles.
    always_comb begin
        n_ex  = 2'd0;
        n_mem = 2'd0;
        n_wb  = 2'd0;
        unique case (1'b1)
            hit_ex && ex_RegDst == REGDST_MEM:  n_ex = N_LD;
            hit_ex && ex_RegDst == REGDST_LINK: n_ex = N_LK;
            default:                            n_ex = 2'd0;
        endcase
        if (hit_mem && mem_RegDst == REGDST_LINK) n_mem = N_LK1;
        if (hit_wb && wb_RegDst == REGDST_LINK)   n_wb = N_LK2;
        n_max = (n_ex > n_mem) ? n_ex : n_mem;
        need  = (n_max > n_wb) ? n_max : n_wb;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble counter, stall
// sequencing and flush priority.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int LINK_BUBBLES = 3
) (
    input logic   CLK,
    input logic   RST_n,
    id_ex_if.slave bus
);

    id_ex_t     id_w;
    id_ex_t     ex_q;
    logic [1:0] cnt;
    logic [1:0] need;
    logic       stall;

    assign id_w = '{
        Mwk:       bus.id_Mwk,
        op:        bus.id_op,
        rs1:       bus.id_rs1,
        rs2:       bus.id_rs2,
        rd:        bus.id_rd,
        ReadData1: bus.id_ReadData1,
        ReadData2: bus.id_ReadData2,
        imm:       bus.id_imm,
        pc:        bus.id_pc,
        RegWr:     bus.id_RegWr,
        RegDst:    bus.id_RegDst,
        ALUOp:     bus.id_ALUOp,
        MemWr:     bus.id_MemWr
    };

    hazard_detect #(
        .LOAD_BUBBLES(LOAD_BUBBLES),
        .LINK_BUBBLES(LINK_BUBBLES)
    ) u_hz (
        .id_Mwk    (bus.id_Mwk),
        .use_rs1   (bus.id_use_rs1),
        .use_rs2   (bus.id_use_rs2),
        .rs1       (bus.id_rs1),
        .rs2       (bus.id_rs2),
        .ex_Mwk    (ex_q.Mwk),
        .ex_RegWr  (ex_q.RegWr),
        .ex_RegDst (ex_q.RegDst),
        .ex_rd     (ex_q.rd),
        .mem_Mwk   (bus.mem_Mwk),
        .mem_RegWr (bus.mem_RegWr),
        .mem_RegDst(bus.mem_RegDst),
        .mem_rd    (bus.mem_rd),
        .wb_Mwk    (bus.wb_Mwk),
        .wb_RegWr  (bus.wb_RegWr),
        .wb_RegDst (bus.wb_RegDst),
        .wb_rd     (bus.wb_rd),
        .need      (need)
    );

    // need is only consulted when no stall is in progress
    assign stall = RST_n && !bus.flush &&
                   ((cnt != 2'd0) || (need != 2'd0));

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            ex_q <= '0;
            cnt  <= 2'd0;
        end else if (bus.flush) begin
            ex_q <= '0;
            cnt  <= 2'd0;
        end else if (stall) begin
            ex_q <= '0;
            cnt  <= ((cnt == 2'd0) ? need : cnt) - 2'd1;
        end else begin
            ex_q <= id_w;
            cnt  <= 2'd0;
        end
    end

    assign bus.ex_Mwk       = ex_q.Mwk;
    assign bus.ex_op        = ex_q.op;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_ReadData1 = ex_q.ReadData1;
    assign bus.ex_ReadData2 = ex_q.ReadData2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_RegWr     = ex_q.RegWr;
    assign bus.ex_RegDst    = ex_q.RegDst;
    assign bus.ex_ALUOp     = ex_q.ALUOp;
    assign bus.ex_MemWr     = ex_q.MemWr;
    assign bus.stall        = stall;
    assign bus.bubble_cnt   = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX bundles are
// queued at drive time and popped after each edge.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    id_ex_if bus();

    id_ex_stage dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .bus  (bus)
    );

    int     checks = 0;
    int     failures = 0;
    id_ex_t exp_q[$];
    id_ex_t obs;
    id_ex_t e;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    function automatic id_ex_t mk(
        input logic [6:0]  op,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [1:0]  dst,
        input logic [31:0] d1
    );
        id_ex_t f;
        f.Mwk       = 1'b1;
        f.op        = op;
        f.rs1       = rs1;
        f.rs2       = rs2;
        f.rd        = rd;
        f.ReadData1 = d1;
        f.ReadData2 = ~d1;
        f.imm       = {27'd0, rd} << 2;
        f.pc        = d1 ^ 32'h0000_1000;
        f.RegWr     = 1'b1;
        f.RegDst    = dst;
        f.ALUOp     = op[3:0];
        f.MemWr     = 1'b0;
        return f;
    endfunction

    function automatic id_ex_t ex_obs();
        id_ex_t f;
        f.Mwk       = bus.ex_Mwk;
        f.op        = bus.ex_op;
        f.rs1       = bus.ex_rs1;
        f.rs2       = bus.ex_rs2;
        f.rd        = bus.ex_rd;
        f.ReadData1 = bus.ex_ReadData1;
        f.ReadData2 = bus.ex_ReadData2;
        f.imm       = bus.ex_imm;
        f.pc        = bus.ex_pc;
        f.RegWr     = bus.ex_RegWr;
        f.RegDst    = bus.ex_RegDst;
        f.ALUOp     = bus.ex_ALUOp;
        f.MemWr     = bus.ex_MemWr;
        return f;
    endfunction

    task automatic set_id(input id_ex_t f, input logic u1, input logic u2);
        bus.id_Mwk       = f.Mwk;
        bus.id_op        = f.op;
        bus.id_rs1       = f.rs1;
        bus.id_rs2       = f.rs2;
        bus.id_rd        = f.rd;
        bus.id_ReadData1 = f.ReadData1;
        bus.id_ReadData2 = f.ReadData2;
        bus.id_imm       = f.imm;
        bus.id_pc        = f.pc;
        bus.id_RegWr     = f.RegWr;
        bus.id_RegDst    = f.RegDst;
        bus.id_ALUOp     = f.ALUOp;
        bus.id_MemWr     = f.MemWr;
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        #1;
    endtask

    task automatic set_mw(
        input logic       mv,
        input logic [1:0] md,
        input logic [4:0] mr,
        input logic       wv,
        input logic [1:0] wd,
        input logic [4:0] wr
    );
        bus.mem_Mwk    = mv;
        bus.mem_RegWr  = mv;
        bus.mem_RegDst = md;
        bus.mem_rd     = mr;
        bus.wb_Mwk     = wv;
        bus.wb_RegWr   = wv;
        bus.wb_RegDst  = wd;
        bus.wb_rd      = wr;
        #1;
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        id_ex_t a;
        a = mk(OP_ADD, 5'd2, 5'd3, 5'd6, REGDST_ALU, 32'h1234);
        RST_n = 1'b0;
        set_id(a, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_stall got=%b exp=0", bus.stall);
            end
            exp_q.push_back('0);
            cycle();
            e = exp_q.pop_front(); obs = ex_obs(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_ex got=%h exp=%h", obs, e);
            end
            checks++;
            if (bus.bubble_cnt !== 2'd0) begin
                failures++;
                $display("FAIL reset_cnt got=%0d exp=0", bus.bubble_cnt);
            end
        end
        RST_n = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL pass_stall got=%b exp=0", bus.stall);
        end
        exp_q.push_back(a);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL pass_ex got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_load_use();
        id_ex_t l, a;
        l = mk(OP_LW, 5'd2, 5'd0, 5'd5, REGDST_MEM, 32'h5555);
        a = mk(OP_ADD, 5'd5, 5'd1, 5'd6, REGDST_ALU, 32'h6666);
        set_id(l, 1'b1, 1'b0);
        exp_q.push_back(l);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL lu_lw got=%h exp=%h", obs, e);
        end
        set_id(a, 1'b1, 1'b1);
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall got=%b exp=1", bus.stall);
        end
        exp_q.push_back('0);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL lu_bubble got=%h exp=%h", obs, e);
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.bubble_cnt !== 2'd0) begin
            failures++;
            $display("FAIL lu_release stall=%b cnt=%0d exp 0/0",
                     bus.stall, bus.bubble_cnt);
        end
        exp_q.push_back(a);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL lu_add got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_link();
        id_ex_t j, a;
        logic [1:0] ec;
        j = mk(OP_JAL, 5'd0, 5'd0, 5'd1, REGDST_LINK, 32'h40);
        a = mk(OP_ADD, 5'd3, 5'd1, 5'd10, REGDST_ALU, 32'h77);
        set_id(j, 1'b0, 1'b0);
        exp_q.push_back(j);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL link_jal got=%h exp=%h", obs, e);
        end
        set_id(a, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.stall !== 1'b1) begin
                failures++;
                $display("FAIL link_stall%0d got=%b exp=1", i, bus.stall);
            end
            exp_q.push_back('0);
            cycle();
            e = exp_q.pop_front(); obs = ex_obs(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL link_bubble%0d got=%h exp=%h", i, obs, e);
            end
            ec = 2'(2 - i);
            checks++;
            if (bus.bubble_cnt !== ec) begin
                failures++;
                $display("FAIL link_cnt%0d got=%0d exp=%0d",
                         i, bus.bubble_cnt, ec);
            end
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL link_release got=%b exp=0", bus.stall);
        end
        exp_q.push_back(a);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL link_held got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_flush();
        id_ex_t j, a, b;
        j = mk(OP_JAL, 5'd0, 5'd0, 5'd1, REGDST_LINK, 32'h80);
        a = mk(OP_ADD, 5'd1, 5'd4, 5'd11, REGDST_ALU, 32'h99);
        b = mk(OP_ADD, 5'd1, 5'd2, 5'd12, REGDST_CMP, 32'hAB);
        set_id(j, 1'b0, 1'b0);
        exp_q.push_back(j);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL fl_jal got=%h exp=%h", obs, e);
        end
        set_id(a, 1'b1, 1'b1);
        exp_q.push_back('0);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e || bus.bubble_cnt !== 2'd2) begin
            failures++;
            $display("FAIL fl_pre got=%h cnt=%0d exp=%h cnt=2",
                     obs, bus.bubble_cnt, e);
        end
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL fl_stall got=%b exp=0", bus.stall);
        end
        exp_q.push_back('0);
        cycle();
        bus.flush = 1'b0;
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e || bus.bubble_cnt !== 2'd0) begin
            failures++;
            $display("FAIL fl_bubble got=%h cnt=%0d exp=%h cnt=0",
                     obs, bus.bubble_cnt, e);
        end
        set_id(b, 1'b1, 1'b1);
        exp_q.push_back(b);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL fl_next got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_x0_unused();
        id_ex_t l0, l7, u;
        l0 = mk(OP_LW, 5'd3, 5'd0, 5'd0, REGDST_MEM, 32'h10);
        l7 = mk(OP_LW, 5'd0, 5'd0, 5'd7, REGDST_MEM, 32'h20);
        u  = mk(OP_LUI, 5'd7, 5'd7, 5'd8, REGDST_ALU, 32'h30);
        set_id(l0, 1'b1, 1'b0);
        exp_q.push_back(l0);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL x0_lw got=%h exp=%h", obs, e);
        end
        set_id(l7, 1'b1, 1'b0);
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL x0_stall got=%b exp=0", bus.stall);
        end
        exp_q.push_back(l7);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL x0_capture got=%h exp=%h", obs, e);
        end
        set_id(u, 1'b0, 1'b0);
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL unused_stall got=%b exp=0", bus.stall);
        end
        exp_q.push_back(u);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL unused_capture got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_mem_wb();
        id_ex_t l5, a, c, d;
        logic [1:0] ec;
        a = mk(OP_ADD, 5'd4, 5'd0, 5'd13, REGDST_ALU, 32'hC1);
        c = mk(OP_ADD, 5'd9, 5'd8, 5'd14, REGDST_ALU, 32'hC2);
        l5 = mk(OP_LW, 5'd0, 5'd0, 5'd5, REGDST_MEM, 32'hC3);
        d = mk(OP_ADD, 5'd5, 5'd6, 5'd15, REGDST_ALU, 32'hC4);
        // mem link producer: two bubbles, producer advances to wb
        set_mw(1'b1, REGDST_LINK, 5'd4, 1'b0, REGDST_ALU, 5'd0);
        set_id(a, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.stall !== 1'b1) begin
                failures++;
                $display("FAIL mem_stall%0d got=%b exp=1", i, bus.stall);
            end
            exp_q.push_back('0);
            cycle();
            if (i == 0) set_mw(1'b0, REGDST_ALU, 5'd0, 1'b1, REGDST_LINK, 5'd4);
            else set_mw(1'b0, REGDST_ALU, 5'd0, 1'b0, REGDST_ALU, 5'd0);
            e = exp_q.pop_front(); obs = ex_obs(); ec = 2'(1 - i); checks++;
            if (obs !== e || bus.bubble_cnt !== ec) begin
                failures++;
                $display("FAIL mem_bubble%0d got=%h cnt=%0d exp=%h cnt=%0d",
                         i, obs, bus.bubble_cnt, e, ec);
            end
        end
        exp_q.push_back(a);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL mem_held got=%h exp=%h", obs, e);
        end
        // wb link producer: one bubble
        set_mw(1'b0, REGDST_ALU, 5'd0, 1'b1, REGDST_LINK, 5'd8);
        set_id(c, 1'b1, 1'b1);
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL wb_stall got=%b exp=1", bus.stall);
        end
        exp_q.push_back('0);
        cycle();
        set_mw(1'b0, REGDST_ALU, 5'd0, 1'b0, REGDST_ALU, 5'd0);
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e || bus.bubble_cnt !== 2'd0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL wb_bubble got=%h cnt=%0d stall=%b exp=%h 0 0",
                     obs, bus.bubble_cnt, bus.stall, e);
        end
        exp_q.push_back(c);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL wb_held got=%h exp=%h", obs, e);
        end
        // load in mem needs no stall; capture lw x5 meanwhile
        set_mw(1'b1, REGDST_MEM, 5'd5, 1'b0, REGDST_ALU, 5'd0);
        set_id(l5, 1'b0, 1'b0);
        exp_q.push_back(l5);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL memld_capture got=%h exp=%h", obs, e);
        end
        // ex load (1) and mem link (2): maximum wins
        set_mw(1'b1, REGDST_LINK, 5'd6, 1'b0, REGDST_ALU, 5'd0);
        set_id(d, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.stall !== 1'b1) begin
                failures++;
                $display("FAIL max_stall%0d got=%b exp=1", i, bus.stall);
            end
            exp_q.push_back('0);
            cycle();
            if (i == 0) set_mw(1'b0, REGDST_ALU, 5'd0, 1'b1, REGDST_LINK, 5'd6);
            else set_mw(1'b0, REGDST_ALU, 5'd0, 1'b0, REGDST_ALU, 5'd0);
            e = exp_q.pop_front(); obs = ex_obs(); ec = 2'(1 - i); checks++;
            if (obs !== e || bus.bubble_cnt !== ec) begin
                failures++;
                $display("FAIL max_bubble%0d got=%h cnt=%0d exp=%h cnt=%0d",
                         i, obs, bus.bubble_cnt, e, ec);
            end
        end
        exp_q.push_back(d);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL max_held got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_reset_mid();
        id_ex_t j, a;
        j = mk(OP_JAL, 5'd0, 5'd0, 5'd1, REGDST_LINK, 32'hD0);
        a = mk(OP_ADD, 5'd1, 5'd2, 5'd16, REGDST_ALU, 32'hD1);
        set_id(j, 1'b0, 1'b0);
        exp_q.push_back(j);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL rm_jal got=%h exp=%h", obs, e);
        end
        set_id(a, 1'b1, 1'b0);
        cycle();
        cycle();
        checks++;
        if (bus.bubble_cnt !== 2'd1) begin
            failures++;
            $display("FAIL rm_pre cnt=%0d exp=1", bus.bubble_cnt);
        end
        RST_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL rm_stall got=%b exp=0", bus.stall);
        end
        exp_q.push_back('0);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e || bus.bubble_cnt !== 2'd0) begin
            failures++;
            $display("FAIL rm_clear got=%h cnt=%0d exp=%h cnt=0",
                     obs, bus.bubble_cnt, e);
        end
        RST_n = 1'b1;
        #1;
        exp_q.push_back(a);
        cycle();
        e = exp_q.pop_front(); obs = ex_obs(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL rm_after got=%h exp=%h", obs, e);
        end
    endtask

    initial begin
        bus.flush = 1'b0;
        set_mw(1'b0, REGDST_ALU, 5'd0, 1'b0, REGDST_ALU, 5'd0);
        set_id('0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_link();
        test_flush();
        test_x0_unused();
        test_mem_wb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage RV32 pipeline, with load-use / link hazard detection and stall sequencing.
- Registers decoded ID-stage fields into the EX stage. Its registered outputs drive the EX-stage forwarding unit directly (rs1, rs2, ReadData1/2, Mwk, RegWr, RegDst, op, rd).
- Hazards the forwarding unit cannot resolve are handled here: stall IF/ID and inject bubbles.
- Branch/jump flushes resolved in EX are also applied here.

Parameters:
- XLEN, 32, datapath width.
- LOAD_BUBBLES, 1, bubbles inserted when a load in EX feeds the ID instruction.
- LINK_BUBBLES, 3, bubbles inserted when a link-writer (RegDst=10) in EX feeds the ID instruction.

Ports:
- CLK  in  1  clock, all state on posedge.
- RST_n  in  1  synchronous active-low reset, sampled on posedge CLK.
- id_Mwk  in  1  ID slot holds a valid instruction.
- id_op  in  7  opcode.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_ReadData1, id_ReadData2  in  XLEN each  register-file read data.
- id_imm, id_pc  in  XLEN each  immediate, PC.
- id_RegWr  in  1  register-write enable.
- id_RegDst  in  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 compare.
- id_ALUOp  in  4  ALU operation.
- id_MemWr  in  1  store enable.
- mem_Mwk, mem_RegWr  in  1 each  MEM-stage producer status.
- mem_RegDst  in  2  MEM-stage write-back select.
- mem_rd  in  5  MEM-stage destination.
- wb_Mwk, wb_RegWr  in  1 each  WB-stage producer status.
- wb_RegDst  in  2  WB-stage write-back select.
- wb_rd  in  5  WB-stage destination.
- flush  in  1  EX resolved a taken branch/jump.
- ex_*  out  same widths as the id_* fields above (Mwk, op, rs1, rs2, rd, ReadData1, ReadData2, imm, pc, RegWr, RegDst, ALUOp, MemWr)  registered EX-stage fields.
- stall  out  1  combinational; holds PC and IF/ID.
- bubble_cnt  out  2  remaining stall cycles (debug/verification).

Behaviour:
- Reset (RST_n=0 at posedge):
  - All ex_* outputs cleared to 0 and bubble_cnt cleared to 0.
  - stall=0 during reset.
  - Reset overrides flush and any stall in progress.
- Match condition: producer P matches when P_Mwk && P_RegWr && P_rd!=0 && id_Mwk && ((id_use_rs1 && P_rd==id_rs1) || (id_use_rs2 && P_rd==id_rs2)).
  - rd=0 never matches.
  - Unused source fields never match.
- Required bubbles need, evaluated only when bubble_cnt==0:
  - ex producer matches with RegDst=01: LOAD_BUBBLES.
  - ex producer matches with RegDst=10: LINK_BUBBLES.
  - mem producer matches with RegDst=10: LINK_BUBBLES-1.
  - wb producer matches with RegDst=10: LINK_BUBBLES-2.
  - Otherwise 0.
  - With multiple matches, take the maximum.
  - RegDst 00/11 producers in any stage are never stalled on (forwarded downstream).
  - A 01 producer in mem/wb needs no stall.
- stall = !flush && ((bubble_cnt!=0) || (bubble_cnt==0 && need!=0)).
- Per posedge, in priority order:
  - If !RST_n: reset.
  - Else if flush:
    - Bubble loaded (all ex_* = 0).
    - bubble_cnt <= 0; pending stall is cancelled.
  - Else if stall:
    - Bubble loaded.
    - bubble_cnt <= (bubble_cnt==0 ? need : bubble_cnt) - 1.
  - Else: all id_* captured into ex_*; bubble_cnt stays 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- stall deasserts in the cycle bubble_cnt reaches 0. The held instruction is captured on that posedge.
- The detector is not re-evaluated while bubble_cnt!=0. A bubble (ex_Mwk=0) never triggers a stall.
- A bubble is all fields zero, including data fields.

Decomposition:
- Shared package pipe_pkg holds:
  - RegDst encodings: REGDST_ALU=00, REGDST_MEM=01, REGDST_LINK=10, REGDST_CMP=11.
  - XLEN.
  - The ID/EX bundle struct.
- One sub-module, hazard_detect: combinational need computation from the ID and ex/mem/wb producer fields.
- Counter, registers and flush priority live in id_ex_stage.

Test Plan:
- Reset and pass-through:
  - Stimulus: RST_n=0 for 2 cycles, then id_op=0110011, id_rd=6, id_ReadData1=0x1234.
  - Response: all ex_*=0 during reset. Next posedge ex_rd=6, ex_ReadData1=0x1234, stall=0.
- Load-use:
  - Stimulus: lw x5 captured (ex_RegDst=01, ex_rd=5); ID add x6,x5,x1 with use_rs1=1.
  - Response: stall=1 for exactly 1 cycle, ex_Mwk=0 bubble. The add is captured on the next edge.
- Link hazard:
  - Stimulus: jal x1 in EX (RegDst=10, rd=1); ID uses rs2=1.
  - Response: stall=1 for 3 cycles, bubble_cnt 2,1,0, three bubbles. The held instruction is captured on the 4th edge.
- Flush mid-stall:
  - Stimulus: link stall active with bubble_cnt=2; assert flush one cycle.
  - Response: stall=0 that cycle, bubble loaded, bubble_cnt=0. Next ID instruction is captured normally.
- x0 and unused sources:
  - Stimulus: lw x0 in EX with ID using rs1=0.
  - Stimulus: lw x7 in EX with ID lui x7 (use_rs1=use_rs2=0).
  - Response: stall=0 in both cases, no bubble.
- Reset mid-stall:
  - Stimulus: RST_n=0 at posedge while bubble_cnt=1.
  - Response: bubble_cnt=0, ex_*=0, stall=0.
